t_mod_counter_param: RTL and testbench

//   Parametrised modulo-N up/down counter built from T flip-flop cells.

---
 rtl/t_counter_pkg.sv | 28 ++
 rtl/t_ff_cell.sv | 27 ++
 rtl/t_mod_counter_param.sv | 135 +++++++++++++
 tb/tb_t_mod_counter_param.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/t_counter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : t_counter_pkg                                                 |
// | Purpose  : Shared definitions for the T-flip-flop counter family:        |
// |            direction encodings and a constant ceil(log2) helper used     |
// |            when checking counter parameters at elaboration.              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package t_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Number of bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/t_ff_cell.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : t_ff_cell                                                     |
// | Purpose  : Single T flip-flop with asynchronous active-high reset.       |
// | Ports    : clk   - clock, rising edge                                    |
// |            reset - asynchronous reset, forces q to 0                     |
// |            t     - toggle request, q inverts on the edge when high       |
// |            q     - stored bit                                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module t_ff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule
`default_nettype wire

// File: rtl/t_mod_counter_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : t_mod_counter_param                                           |
// | Purpose  : Modulo-MODULUS up/down counter built from T flip-flop cells,  |
// |            with enable, synchronous clear/load and cascade outputs.      |
// | Ports    : clk, reset       - clock / async active-high reset            |
// |            en, up_dn        - count enable / direction (1 = up)          |
// |            clr, load        - sync clear / sync load (clr has priority)  |
// |            load_val         - value for load                             |
// |            q                - registered count                           |
// |            tc, carry_out    - terminal count / cascade enable (comb.)    |
// |            wrap, load_err   - 1-cycle pulses after a wrap / bad load     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module t_mod_counter_param
  import t_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             carry_out,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] c_max = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] toggle;
  logic             wrap_q;
  logic             wrap_d;
  logic             load_err_q;
  logic             load_err_d;
  logic             q_oor;      // count above c_max (only via X/forced state)
  logic             lv_oor;     // load_val above c_max
  logic             at_max;
  logic             at_zero;

  generate
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("t_mod_counter_param: WIDTH %0d outside 1..16", WIDTH);
    end
    if (MODULUS < 2 || clog2(MODULUS) > WIDTH) begin : g_bad_modulus
      $error("t_mod_counter_param: MODULUS %0d outside 2..2**WIDTH", MODULUS);
    end

    // A full binary modulus leaves no unused codes, so neither the count nor
    // a load value can ever be out of range.
    if (MODULUS == (1 << WIDTH)) begin : g_full_range
      assign q_oor  = 1'b0;
      assign lv_oor = 1'b0;
    end else begin : g_part_range
      assign q_oor  = (count_q > c_max);
      assign lv_oor = (load_val > c_max);
    end
  endgenerate

  assign at_max  = (count_q == c_max);
  assign at_zero = (count_q == '0);

  // Next-count mux: clr > load > en > hold.
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      if (lv_oor) begin
        count_d    = c_max;
        load_err_d = 1'b1;
      end else begin
        count_d = load_val;
      end
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        if (at_max || q_oor) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (at_zero || q_oor) begin
          count_d = c_max;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // Each cell toggles exactly where the next count differs from the current.
  assign toggle = count_q ^ count_d;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      t_ff_cell u_cell (
        .clk   (clk),
        .reset (reset),
        .t     (toggle[i]),
        .q     (count_q[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign q         = count_q;
  assign tc        = (up_dn == DIR_UP) ? at_max : at_zero;
  assign carry_out = en & tc & ~clr & ~load;
  assign wrap      = wrap_q;
  assign load_err  = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_t_mod_counter_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_t_mod_counter_param                                        |
// | Purpose  : Self-checking bench: table of directed vectors for a mod-6    |
// |            counter, async reset sequences, a full-range mod-8 counter    |
// |            and a two-stage mod-6 cascade (0..35).                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_t_mod_counter_param;

  typedef struct {
    logic       en;
    logic       up;
    logic       clr;
    logic       ld;
    logic [3:0] lv;
    logic [3:0] q;
    logic       tc;
    logic       co;
    logic       wr;
    logic       le;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, up_dn = 1'b1, clr = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] q;
  logic       tc, carry_out, wrap, load_err;

  logic       f_en = 1'b0, f_up = 1'b1, f_ld = 1'b0;
  logic [2:0] f_lv = 3'd0;
  logic [2:0] f_q;
  logic       f_tc, f_co, f_wrap, f_lerr;

  logic       ch_en = 1'b0;
  logic [3:0] c0_q, c1_q;
  logic       c0_tc, c0_co, c0_wrap, c0_lerr;
  logic       c1_tc, c1_co, c1_wrap, c1_lerr;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vt [28];

  always #5 clk = ~clk;

  t_mod_counter_param #(.WIDTH(4), .MODULUS(6)) u_dut (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .q(q), .tc(tc), .carry_out(carry_out), .wrap(wrap),
    .load_err(load_err)
  );

  t_mod_counter_param #(.WIDTH(3), .MODULUS(8)) u_full (
    .clk(clk), .reset(reset), .en(f_en), .up_dn(f_up), .clr(1'b0), .load(f_ld),
    .load_val(f_lv), .q(f_q), .tc(f_tc), .carry_out(f_co), .wrap(f_wrap),
    .load_err(f_lerr)
  );

  t_mod_counter_param #(.WIDTH(4), .MODULUS(6)) u_ch0 (
    .clk(clk), .reset(reset), .en(ch_en), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .q(c0_q), .tc(c0_tc), .carry_out(c0_co), .wrap(c0_wrap),
    .load_err(c0_lerr)
  );

  t_mod_counter_param #(.WIDTH(4), .MODULUS(6)) u_ch1 (
    .clk(clk), .reset(reset), .en(c0_co), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .q(c1_q), .tc(c1_tc), .carry_out(c1_co), .wrap(c1_wrap),
    .load_err(c1_lerr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic [3:0] eq, input logic etc,
                          input logic eco, input logic ewr, input logic ele);
    chk({tag, " q"}, 32'(q), 32'(eq));
    chk({tag, " tc"}, 32'(tc), 32'(etc));
    chk({tag, " carry_out"}, 32'(carry_out), 32'(eco));
    chk({tag, " wrap"}, 32'(wrap), 32'(ewr));
    chk({tag, " load_err"}, 32'(load_err), 32'(ele));
  endtask

  initial begin
    //           en    up    clr   ld    lv     q      tc    co    wr    le
    vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[22] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[23] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[24] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[25] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[26] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[27] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held for two edges with en high: nothing may move.
    en = 1'b1;
    up_dn = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_main("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      en = vt[i].en;
      up_dn = vt[i].up;
      clr = vt[i].clr;
      load = vt[i].ld;
      load_val = vt[i].lv;
      @(posedge clk);
      #1;
      chk_main($sformatf("vec%0d", i), vt[i].q, vt[i].tc, vt[i].co, vt[i].wr, vt[i].le);
    end

    // Asynchronous reset between edges while counting (q=3).
    @(negedge clk);
    en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b1; load_val = 4'd2;
    @(negedge clk);
    en = 1'b1; load = 1'b0;
    @(posedge clk);
    #1;
    chk("async pre q", 32'(q), 32'd3);
    #1 reset = 1'b1;
    #1;
    chk("async reset q", 32'(q), 32'd0);
    @(negedge clk);
    reset = 1'b0; en = 1'b0; load = 1'b1; load_val = 4'd9;
    @(posedge clk);
    #1;
    chk("async pre load_err", 32'(load_err), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async reset load_err", 32'(load_err), 32'd0);
    chk("async reset q2", 32'(q), 32'd0);
    @(negedge clk);
    reset = 1'b0; load = 1'b0;

    // Full binary modulus (8 codes on 3 bits): natural wrap, no load error.
    @(negedge clk);
    f_ld = 1'b1; f_lv = 3'd7; f_up = 1'b1;
    @(posedge clk);
    #1;
    chk("full load q", 32'(f_q), 32'd7);
    chk("full load_err", 32'(f_lerr), 32'd0);
    chk("full tc", 32'(f_tc), 32'd1);
    @(negedge clk);
    f_ld = 1'b0; f_en = 1'b1;
    @(posedge clk);
    #1;
    chk("full up wrap q", 32'(f_q), 32'd0);
    chk("full up wrap", 32'(f_wrap), 32'd1);
    @(negedge clk);
    f_up = 1'b0;
    @(posedge clk);
    #1;
    chk("full dn wrap q", 32'(f_q), 32'd7);
    chk("full dn wrap", 32'(f_wrap), 32'd1);
    @(negedge clk);
    f_en = 1'b0;
    @(posedge clk);
    #1;
    chk("full hold wrap", 32'(f_wrap), 32'd0);

    // Two mod-6 stages cascaded: combined value runs 0..35 and wraps to 0.
    @(negedge clk);
    ch_en = 1'b1;
    for (int k = 1; k <= 37; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("chain step %0d", k), 32'(c1_q) * 32'd6 + 32'(c0_q), 32'(k % 36));
    end
    ch_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
